// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the round-robin bus arbiter.
//   - ARB_FIXED / ARB_RR : selection-mode constants for the MODE parameter
//   - arb_state_e        : grant state machine encoding (IDLE = 0, GRANT = 1)
//   - hold_width()       : width of the hold counter for a given MAX_HOLD
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Counter must reach MAX_HOLD; keep at least one bit so MAX_HOLD = 0 still elaborates.
  function automatic int hold_width(input int max_hold);
    if (max_hold < 1) begin
      return 1;
    end else begin
      return $clog2(max_hold + 1);
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotating priority encoder.
//   i_req    [NREQ-1:0] request vector
//   i_start  [OW-1:0]   index given highest priority; search wraps past NREQ-1 to 0
//   o_winner [OW-1:0]   first requesting index found from i_start upward (0 if none)
//   o_valid             any request present
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter  int NREQ = 8,
  localparam int OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [OW-1:0]   i_start,
  output logic [OW-1:0]   o_winner,
  output logic            o_valid
);

  logic [OW:0] w_idx;
  logic        w_found;

  // Walk the requests starting at i_start, wrapping modulo NREQ; first hit wins.
  always_comb begin
    w_idx    = '0;
    w_found  = 1'b0;
    o_winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = {1'b0, i_start} + (OW+1)'(i);
      // NREQ need not be a power of two, so wrap explicitly.
      if (w_idx >= (OW+1)'(NREQ)) begin
        w_idx = w_idx - (OW+1)'(NREQ);
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && i_req[w_idx[OW-1:0]]) begin
        w_found  = 1'b1;
        o_winner = w_idx[OW-1:0];
      end else begin
        w_found  = w_found;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: N-master system bus arbiter with a registered grant FSM.
//   i_clk             system clock
//   i_rst             synchronous active-high reset
//   i_bus_req         per-master request, held high for the whole tenure
//   i_bus_ready       slave finished the current beat (transaction boundary)
//   o_bus_ack         one-hot grant (registered)
//   o_bus_owner       index of the current/last grantee (registered), steers bus muxes
//   o_bus_owner_valid high exactly when o_bus_ack != 0
// MODE selects fixed priority (lowest index) or rotating priority. With MAX_HOLD > 0
// an owner that has held the bus MAX_HOLD cycles is dropped at a ready beat when
// another master is waiting. Every handoff passes through IDLE (one dead cycle).
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter  int NREQ     = 8,
  parameter  int MODE     = ARB_RR,
  parameter  int MAX_HOLD = 0,
  localparam int OW       = $clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_bus_req,
  input  logic            i_bus_ready,
  output logic [NREQ-1:0] o_bus_ack,
  output logic [OW-1:0]   o_bus_owner,
  output logic            o_bus_owner_valid
);

  localparam int HW = hold_width(MAX_HOLD);

  arb_state_e      r_state;
  logic [NREQ-1:0] r_ack;
  logic [OW-1:0]   r_owner;
  logic            r_valid;
  logic [HW-1:0]   r_hold;
  logic [OW-1:0]   r_rr_last;

  logic [OW-1:0]   w_start;
  logic [OW-1:0]   w_winner;
  logic            w_any;
  logic [NREQ-1:0] w_onehot;
  logic            w_contend;
  logic            w_preempt;

  // Search start: one past the last released owner in RR mode, index 0 in fixed mode.
  always_comb begin
    w_start = '0;
    if (MODE == ARB_RR) begin
      if (r_rr_last == OW'(NREQ - 1)) begin
        w_start = '0;
      end else begin
        w_start = r_rr_last + OW'(1);
      end
    end else begin
      w_start = '0;
    end
  end

  rr_priority_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req    (i_bus_req),
    .i_start  (w_start),
    .o_winner (w_winner),
    .o_valid  (w_any)
  );

  assign w_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
  // Someone other than the owner is asking for the bus.
  assign w_contend = |(i_bus_req & ~r_ack);

  // Preemption: hold time used up, contention, and a transaction boundary.
  always_comb begin
    w_preempt = 1'b0;
    if (MAX_HOLD > 0) begin
      w_preempt = (r_hold >= HW'(MAX_HOLD)) && w_contend && i_bus_ready;
    end else begin
      w_preempt = 1'b0;
    end
  end

  // Grant state machine with registered ack/owner/valid outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_ack     <= '0;
      r_owner   <= '0;
      r_valid   <= 1'b0;
      r_hold    <= '0;
      r_rr_last <= OW'(NREQ - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_ack   <= w_onehot;
            r_owner <= w_winner;
            r_valid <= 1'b1;
            r_hold  <= '0;
          end else begin
            r_ack   <= '0;
            r_valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          // Release wins over a simultaneous preemption; bus_owner keeps its value.
          if (!i_bus_req[r_owner]) begin
            r_state <= ST_IDLE;
            r_ack   <= '0;
            r_valid <= 1'b0;
            if (MODE == ARB_RR) begin
              r_rr_last <= r_owner;
            end else begin
              r_rr_last <= r_rr_last;
            end
          end else if (w_preempt) begin
            r_state   <= ST_IDLE;
            r_ack     <= '0;
            r_valid   <= 1'b0;
            r_rr_last <= r_owner;
          end else if (r_hold < HW'(MAX_HOLD)) begin
            r_hold <= r_hold + HW'(1);
          end else begin
            r_hold <= r_hold;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= '0;
          r_valid <= 1'b0;
          r_hold  <= '0;
        end
      endcase
    end
  end

  assign o_bus_ack         = r_ack;
  assign o_bus_owner       = r_owner;
  assign o_bus_owner_valid = r_valid;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: instance A (round robin, MAX_HOLD = 4) and instance B
// (fixed priority, MAX_HOLD = 0), driven by directed vectors. A behavioural model
// of each instance is compared every cycle; literal expectations pin the scenarios.
module tb_rr_bus_arbiter;
  import arb_pkg::*;

  logic       clk;
  logic       rst;
  logic       ready;
  logic [7:0] req_a, req_b;
  logic [7:0] ack_a, ack_b;
  logic [2:0] own_a, own_b;
  logic       val_a, val_b;

  int checks;
  int failures;
  bit chk_en;

  rr_bus_arbiter #(.NREQ(8), .MODE(ARB_RR), .MAX_HOLD(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_bus_req(req_a), .i_bus_ready(ready),
    .o_bus_ack(ack_a), .o_bus_owner(own_a), .o_bus_owner_valid(val_a));

  rr_bus_arbiter #(.NREQ(8), .MODE(ARB_FIXED), .MAX_HOLD(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_bus_req(req_b), .i_bus_ready(ready),
    .o_bus_ack(ack_b), .o_bus_owner(own_b), .o_bus_owner_valid(val_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  int m_owner [2];   // current grantee, -1 when nobody holds the bus
  int m_out   [2];   // last grantee index shown on bus_owner
  int m_hold  [2];   // cycles the current tenure has lasted (saturating)
  int m_last  [2];   // last released/preempted owner for rotation
  int p_mode  [2] = '{ARB_RR, ARB_FIXED};
  int p_max   [2] = '{4, 0};

  function automatic int pick(input logic [7:0] req, input int mode, input int last);
    int idx;
    for (int k = 0; k < 8; k++) begin
      idx = (mode == ARB_FIXED) ? k : (last + 1 + k) % 8;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step(input int j, input logic [7:0] req, input logic rdy, input logic rs);
    int w;
    logic [7:0] others;
    if (rs) begin
      m_owner[j] = -1; m_out[j] = 0; m_hold[j] = 0; m_last[j] = 7;
    end else if (m_owner[j] < 0) begin
      w = pick(req, p_mode[j], m_last[j]);
      if (w >= 0) begin
        m_owner[j] = w; m_out[j] = w; m_hold[j] = 0;
      end
    end else if (!req[m_owner[j]]) begin
      if (p_mode[j] == ARB_RR) m_last[j] = m_owner[j];
      m_owner[j] = -1;
    end else begin
      others = req;
      others[m_owner[j]] = 1'b0;
      if (p_max[j] > 0 && m_hold[j] >= p_max[j] && others != 8'h00 && rdy) begin
        m_last[j]  = m_owner[j];
        m_owner[j] = -1;
      end else if (m_hold[j] < p_max[j]) begin
        m_hold[j] = m_hold[j] + 1;
      end
    end
  endtask

  initial begin
    chk_en = 1'b0;
    forever begin
      @(posedge clk);
      step(0, req_a, ready, rst);
      step(1, req_b, ready, rst);
      chk_en = 1'b1;
    end
  end

  task automatic cmp(input int j, input logic [7:0] ack, input logic [2:0] own, input logic val);
    logic [7:0] e_ack;
    logic [2:0] e_own;
    int         tmp;
    e_ack = 8'h00;
    if (m_owner[j] >= 0) e_ack = 8'h01 << m_owner[j];
    tmp   = m_out[j];
    e_own = tmp[2:0];
    checks++;
    if (ack !== e_ack || own !== e_own || val !== (m_owner[j] >= 0)) begin
      failures++;
      $display("FAIL model_%0s t=%0t ack=%h/%h owner=%0d/%0d valid=%b/%b (got/expected)",
               (j == 0) ? "A" : "B", $time, ack, e_ack, own, e_own, val, (m_owner[j] >= 0));
    end
  endtask

  // Per-cycle comparison of both instances against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp(0, ack_a, own_a, val_a);
        cmp(1, ack_b, own_b, val_b);
      end
    end
  end

  // ---------------- literal expectations ----------------
  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int order [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; ready = 1'b0; req_a = 8'h00; req_b = 8'h00;
    tick(); tick();
    lit("reset_ack", ack_a, 8'h00);
    lit("reset_owner", {5'd0, own_a}, 8'h00);
    lit("reset_valid", {7'd0, val_a}, 8'h00);
    rst = 1'b0;

    // Single master: one-cycle latency, release one edge after req falls.
    req_a = 8'h01;
    for (int i = 0; i < 4; i++) begin
      tick();
      lit("single_ack", ack_a, 8'h01);
      lit("single_valid", {7'd0, val_a}, 8'h01);
    end
    req_a = 8'h00;
    tick();
    lit("single_release_ack", ack_a, 8'h00);
    lit("single_release_owner", {5'd0, own_a}, 8'h00);

    // Round-robin fairness with one idle cycle between tenures.
    do_reset();
    for (int t = 0; t < 6; t++) begin
      req_a = 8'h0B;
      tick();
      lit("rr_grant", ack_a, 8'h01 << order[t]);
      lit("rr_owner", {5'd0, own_a}, 8'(order[t]));
      tick();
      lit("rr_hold", ack_a, 8'h01 << order[t]);
      req_a = 8'h0B & ~(8'h01 << order[t]);
      tick();
      lit("rr_idle", ack_a, 8'h00);
    end
    req_a = 8'h00;

    // Fixed priority on B: master 1 always wins; MAX_HOLD = 0 never preempts.
    ready = 1'b1;
    req_b = 8'h06;
    for (int i = 0; i < 10; i++) begin
      tick();
      lit("fixed_hold", ack_b, 8'h02);
    end
    for (int t = 0; t < 3; t++) begin
      req_b = 8'h04;
      tick();
      lit("fixed_idle", ack_b, 8'h00);
      req_b = 8'h06;
      tick();
      lit("fixed_regrant", ack_b, 8'h02);
    end
    req_b = 8'h00;
    ready = 1'b0;

    // Preemption on A: gated by bus_ready, then master 5 takes over.
    do_reset();
    req_a = 8'h01;
    tick();
    lit("pre_grant", ack_a, 8'h01);
    tick(); tick();
    req_a = 8'h21;
    for (int i = 0; i < 4; i++) begin
      tick();
      lit("pre_gated", ack_a, 8'h01);
    end
    ready = 1'b1;
    tick();
    lit("pre_drop", ack_a, 8'h00);
    lit("pre_drop_valid", {7'd0, val_a}, 8'h00);
    ready = 1'b0;
    tick();
    lit("pre_newowner_ack", ack_a, 8'h20);
    lit("pre_newowner_idx", {5'd0, own_a}, 8'h05);
    req_a = 8'h01;
    tick();
    lit("pre_release", ack_a, 8'h00);
    tick();
    lit("pre_back_to_0", ack_a, 8'h01);

    // Reset mid-tenure while master 2 owns the bus.
    req_a = 8'h04;
    tick();
    tick();
    lit("mid_pre_ack", ack_a, 8'h04);
    rst = 1'b1;
    tick();
    lit("mid_rst_ack", ack_a, 8'h00);
    lit("mid_rst_owner", {5'd0, own_a}, 8'h00);
    lit("mid_rst_valid", {7'd0, val_a}, 8'h00);
    rst = 1'b0;
    req_a = 8'h05;
    tick();
    lit("post_rst_first", ack_a, 8'h01);
    req_a = 8'h00;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
